// File: rtl/bus_mem_slave.sv
// Memory target for the CPU/MEM request bus: rq/gnt ownership, start-qualified
// single/burst transfers, rdy-qualified beats. BUS_MEM_RANGE_CHK_EN enables err on out-of-range beats.
module bus_mem_slave #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rq,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              gnt,
  output logic              rdy,
  output logic [DWIDTH-1:0] rdata,
  output logic              err
);

  localparam int IW  = $clog2(DEPTH);
  localparam int WCW = $clog2(WAIT_CYCLES + 2);
  localparam int BCW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    WAIT    = 2'd2,
    BEAT    = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              wr_q, wr_n;
  logic [AWIDTH-1:0] addr_q, addr_n;
  logic [BCW-1:0]    beats_q, beats_n;
  logic [WCW-1:0]    wait_q, wait_n;
  logic [DWIDTH-1:0] rdata_q;
  logic              cur_oor, nxt_oor;

  logic [DWIDTH-1:0] mem [DEPTH];

`ifdef BUS_MEM_RANGE_CHK_EN
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  assign cur_oor = ({1'b0, addr_q} >= DEPTH_W);
  assign nxt_oor = ({1'b0, addr_n} >= DEPTH_W);
`else
  assign cur_oor = 1'b0;
  assign nxt_oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      beats_q <= '0;
      wait_q  <= '0;
    end else begin
      state   <= state_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      beats_q <= beats_n;
      wait_q  <= wait_n;
    end
  end

  always_comb begin
    state_n = state;
    wr_n    = wr_q;
    addr_n  = addr_q;
    beats_n = beats_q;
    wait_n  = wait_q;
    unique case (state)
      IDLE: begin
        if (rq) state_n = GRANTED;
      end
      GRANTED: begin
        if (start) begin
          wr_n    = mode[0];
          addr_n  = addr;
          beats_n = mode[1] ? BCW'(BURST_LEN) : BCW'(1);
          wait_n  = WCW'(WAIT_CYCLES);
          state_n = (WAIT_CYCLES == 0) ? BEAT : WAIT;
        end else if (!rq) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        wait_n = wait_q - WCW'(1);
        if (wait_q <= WCW'(1)) state_n = BEAT;
      end
      BEAT: begin
        if (beats_q <= BCW'(1)) begin
          state_n = GRANTED;
        end else begin
          beats_n = beats_q - BCW'(1);
          addr_n  = addr_q + AWIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // rdata is registered, so it is fetched on the edge that enters each read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_n == BEAT && !wr_n) begin
      rdata_q <= nxt_oor ? '0 : mem[addr_n[IW-1:0]];
    end
  end

  // state resets asynchronously, so a write beat cut short by reset never commits
  always_ff @(posedge clk) begin
    if (state == BEAT && wr_q && !cur_oor) mem[addr_q[IW-1:0]] <= wdata;
  end

  assign gnt   = (state != IDLE);
  assign rdy   = (state == BEAT);
  assign err   = (state == BEAT) && cur_oor;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: three instances (WAIT_CYCLES 1, 0 and 3/DEPTH 64)
// sharing clock and reset, each with its own bus signals.
module tb_bus_mem_slave;

`ifdef BUS_MEM_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rq      [3];
  logic       start   [3];
  logic [1:0] mode    [3];
  logic [7:0] addr    [3];
  logic [7:0] wdata   [3];
  logic       gnt_o   [3];
  logic       rdy_o   [3];
  logic [7:0] rdata_o [3];
  logic       err_o   [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_mem_slave #(.DWIDTH(8), .AWIDTH(8), .DEPTH(256), .WAIT_CYCLES(1), .BURST_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rq(rq[0]), .start(start[0]), .mode(mode[0]), .addr(addr[0]),
    .wdata(wdata[0]), .gnt(gnt_o[0]), .rdy(rdy_o[0]), .rdata(rdata_o[0]), .err(err_o[0]));

  bus_mem_slave #(.DWIDTH(8), .AWIDTH(8), .DEPTH(256), .WAIT_CYCLES(0), .BURST_LEN(4)) u_w0 (
    .clk(clk), .rst_n(rst_n), .rq(rq[1]), .start(start[1]), .mode(mode[1]), .addr(addr[1]),
    .wdata(wdata[1]), .gnt(gnt_o[1]), .rdy(rdy_o[1]), .rdata(rdata_o[1]), .err(err_o[1]));

  bus_mem_slave #(.DWIDTH(8), .AWIDTH(8), .DEPTH(64), .WAIT_CYCLES(3), .BURST_LEN(4)) u_w3 (
    .clk(clk), .rst_n(rst_n), .rq(rq[2]), .start(start[2]), .mode(mode[2]), .addr(addr[2]),
    .wdata(wdata[2]), .gnt(gnt_o[2]), .rdy(rdy_o[2]), .rdata(rdata_o[2]), .err(err_o[2]));

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single transfer starting from GRANTED; ends at the negedge of the GRANTED cycle after rdy.
  task automatic xfer(input int d, input int wc, input bit pulse, input logic [1:0] m,
                      input logic [7:0] a, input logic [7:0] wd, input logic [7:0] exp_rd,
                      input logic exp_err, input string tag);
    start[d] = 1'b1; mode[d] = m; addr[d] = a; wdata[d] = wd;
    tick;
    start[d] = 1'b0;
    for (int i = 0; i < wc; i++) begin
      if (pulse && i == 0) begin
        start[d] = 1'b1; mode[d] = 2'b11; addr[d] = 8'h11;
      end
      check({tag, "_wait_rdy"}, rdy_o[d], 1'b0);
      tick;
      start[d] = 1'b0;
    end
    check({tag, "_rdy"}, rdy_o[d], 1'b1);
    check({tag, "_err"}, err_o[d], exp_err);
    if (!m[0]) check({tag, "_rdata"}, rdata_o[d], exp_rd);
    tick;
    check({tag, "_done_rdy"}, rdy_o[d], 1'b0);
    check({tag, "_done_err"}, err_o[d], 1'b0);
  endtask

  // Four-beat burst on u_dut (one wait state).
  task automatic burst(input logic wr, input logic [7:0] a, input logic [7:0] base, input string tag);
    start[0] = 1'b1; mode[0] = {1'b1, wr}; addr[0] = a;
    tick;
    start[0] = 1'b0;
    check({tag, "_wait_rdy"}, rdy_o[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      wdata[0] = base + 8'(i);
      check({tag, "_beat_rdy"}, rdy_o[0], 1'b1);
      if (!wr) check({tag, "_beat_rdata"}, rdata_o[0], base + 8'(i));
    end
    tick;
    check({tag, "_end_rdy"}, rdy_o[0], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rq[d] = 1'b1; start[d] = 1'b0; mode[d] = 2'b00; addr[d] = '0; wdata[d] = '0;
    end
    tick; tick;
    check("rst_gnt", gnt_o[0], 1'b0);
    check("rst_rdy", rdy_o[0], 1'b0);
    check("rst_rdata", rdata_o[0], 8'h00);
    check("rst_err", err_o[0], 1'b0);

    rst_n = 1'b1;
    check("gnt_before_edge", gnt_o[0], 1'b0);
    tick;
    check("gnt_after_rq", gnt_o[0], 1'b1);
    check("gnt_after_rq_w0", gnt_o[1], 1'b1);
    check("gnt_after_rq_w3", gnt_o[2], 1'b1);
    rq[0] = 1'b0;
    tick;
    check("gnt_drop", gnt_o[0], 1'b0);
    rq[0] = 1'b1;
    tick;
    check("gnt_regrant", gnt_o[0], 1'b1);

    xfer(0, 1, 1'b0, 2'b01, 8'h10, 8'hA5, 8'h00, 1'b0, "wr10");
    xfer(0, 1, 1'b0, 2'b00, 8'h10, 8'h00, 8'hA5, 1'b0, "rd10");
    check("rdata_hold", rdata_o[0], 8'hA5);

    burst(1'b1, 8'hFE, 8'h01, "bwr_fe");
    burst(1'b0, 8'hFE, 8'h01, "brd_fe");
    xfer(0, 1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h03, 1'b0, "rd00_wrap");

    // rq dropped during a burst read
    start[0] = 1'b1; mode[0] = 2'b10; addr[0] = 8'hFE;
    tick;
    start[0] = 1'b0; rq[0] = 1'b0;
    check("rqdrop_wait_rdy", rdy_o[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rqdrop_beat_rdy", rdy_o[0], 1'b1);
      check("rqdrop_beat_gnt", gnt_o[0], 1'b1);
      check("rqdrop_beat_rdata", rdata_o[0], 8'h01 + 8'(i));
    end
    tick;
    check("rqdrop_l1_rdy", rdy_o[0], 1'b0);
    check("rqdrop_l1_gnt", gnt_o[0], 1'b1);
    tick;
    check("rqdrop_l2_gnt", gnt_o[0], 1'b0);
    rq[0] = 1'b1;
    tick;
    check("rqdrop_regrant", gnt_o[0], 1'b1);

    xfer(1, 0, 1'b0, 2'b01, 8'h20, 8'h3C, 8'h00, 1'b0, "w0_wr20");
    xfer(1, 0, 1'b0, 2'b00, 8'h20, 8'h00, 8'h3C, 1'b0, "w0_rd20");

    xfer(2, 3, 1'b0, 2'b01, 8'h10, 8'h11, 8'h00, 1'b0, "w3_wr10");
    xfer(2, 3, 1'b1, 2'b01, 8'h50, 8'h77, 8'h00, RC, "w3_wr50");
    tick;
    check("w3_no_extra_rdy", rdy_o[2], 1'b0);
    xfer(2, 3, 1'b0, 2'b00, 8'h10, 8'h00, RC ? 8'h11 : 8'h77, 1'b0, "w3_rd10");
    xfer(2, 3, 1'b0, 2'b00, 8'h50, 8'h00, RC ? 8'h00 : 8'h77, RC, "w3_rd50");

    // reset asserted during the third beat of a burst write
    burst(1'b1, 8'h40, 8'h10, "bwr_40");
    start[0] = 1'b1; mode[0] = 2'b11; addr[0] = 8'h40;
    tick;
    start[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      wdata[0] = 8'hE0 + 8'(i);
      check("abort_beat_rdy", rdy_o[0], 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_gnt", gnt_o[0], 1'b0);
    check("abort_rdy", rdy_o[0], 1'b0);
    check("abort_rdata", rdata_o[0], 8'h00);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("abort_regrant", gnt_o[0], 1'b1);
    start[0] = 1'b1; mode[0] = 2'b10; addr[0] = 8'h40;
    tick;
    start[0] = 1'b0;
    tick; check("abort_rd0", rdata_o[0], 8'hE0);
    tick; check("abort_rd1", rdata_o[0], 8'hE1);
    tick; check("abort_rd2_old", rdata_o[0], 8'h12);
    tick; check("abort_rd3_old", rdata_o[0], 8'h13);
    tick; check("abort_end_rdy", rdy_o[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
# bus_mem_slave

Parametrised memory target for the CPU/MEM request bus: accepts rq/gnt arbitration and start-qualified transfers, then returns rdy-qualified data beats. Successor to the fixed 8-bit MEM endpoint. Adds configurable data/address width and depth, programmable wait states, split read/write data paths instead of inout, and incrementing bursts. Sits on the MEM side of the bus, directly behind the CPU-side master.

## Interface
Parameters:
- DWIDTH, 8, data width in bits
- AWIDTH, 8, address width in bits
- DEPTH, 256, number of words; power of 2, at most 2**AWIDTH
- WAIT_CYCLES, 1, wait states between start and the first rdy beat (0 allowed)
- BURST_LEN, 4, beats per burst transfer (>=2)

Ports:
- clk  in  1  bus clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rq  in  1  master requests ownership
- start  in  1  one-cycle transfer start; qualifies mode and addr
- mode  in  2  00 single read, 01 single write, 10 burst read, 11 burst write
- addr  in  AWIDTH  start address, sampled with start
- wdata  in  DWIDTH  write data, sampled in every cycle where rdy=1 on a write
- gnt  out  1  ownership granted
- rdy  out  1  one beat completes this cycle
- rdata  out  DWIDTH  read data, valid when rdy=1 on a read
- err  out  1  beat rejected, valid with rdy (see Configuration)

## Operation
- FSM states: IDLE, GRANTED, WAIT, BEAT.
- IDLE: gnt=0. rq=1 -> GRANTED.
- GRANTED: gnt=1.
  - start=1 captures mode, addr and beat count (1 or BURST_LEN), loads wait counter = WAIT_CYCLES -> WAIT, or -> BEAT if WAIT_CYCLES=0.
  - rq=0 with start=0 -> IDLE.
  - rq=0 with start=1: start wins.
- WAIT: counter decrements each cycle; reaching 0 -> BEAT.
- BEAT: rdy=1.
  - Read: rdata = mem[addr].
  - Write: mem[addr] <= wdata at the end of the cycle.
  - Beats remaining -> stay in BEAT with addr+1; beats are back-to-back, with no wait states after the first.
  - Last beat -> GRANTED.
- Burst address wraps modulo DEPTH (DEPTH-1 -> 0).
- start outside GRANTED is ignored. mode/addr/start changes mid-transfer have no effect.
- rq dropped mid-transfer: the transfer runs to completion, then GRANTED -> IDLE on the next cycle.
- gnt stays 1 from GRANTED through the end of the transfer.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: gnt=0, rdy=0, rdata=0, err=0, FSM=IDLE, counters 0. Reset mid-transfer aborts immediately; a pending write beat is not committed.
- rq high at edge N -> gnt=1 from cycle N+1.
- start sampled at edge T -> first rdy in cycle T+1+WAIT_CYCLES. Burst beats occupy consecutive cycles.
- Earliest next start: the cycle after the last rdy.
- rdata is registered and holds its last value when rdy=0. err=0 whenever rdy=0.

## Configuration
- BUS_MEM_RANGE_CHK_EN defined:
  - A beat whose address is >= DEPTH (any bit above log2(DEPTH) set, evaluated per beat before wrap) completes with rdy=1 and err=1.
  - On such a beat, writes are dropped and rdata=0.
  - Burst address increment uses the full AWIDTH; the range check applies per beat.
- Not defined:
  - err is tied to 0.
  - Upper address bits are ignored, so addresses alias modulo DEPTH.

## Test plan
- Reset/handshake: rst_n low with rq=1 -> gnt=0, rdy=0, rdata=0. Release rst_n, hold rq=1 -> gnt=1 the next cycle. Drop rq -> gnt=0 one cycle later.
- Single write then read (WAIT_CYCLES=1): start, mode=01, addr=0x10, wdata=0xA5 -> rdy 2 cycles after start. Then start, mode=00, addr=0x10 -> rdy with rdata=0xA5.
- Burst write/read wrap (DEPTH=256, BURST_LEN=4): mode=11 at addr=0xFE with wdata 1,2,3,4 on consecutive rdy cycles -> 4 back-to-back rdy. Burst read at 0xFE -> rdata 1,2,3,4 from addresses 0xFE, 0xFF, 0x00, 0x01.
- WAIT_CYCLES=0 and =3: start -> rdy at T+1 and T+4 respectively. start pulsed during WAIT is ignored, and no extra beats occur.
- rq dropped during a burst: all 4 beats complete, gnt falls 2 cycles after the last rdy. Reset asserted mid-burst write: the uncommitted beat's address keeps its old value.
- Range check (DEPTH=64, macro on): write to addr=0x50 -> rdy=1, err=1; mem[0x10] unchanged. With the macro off, the same write lands in mem[0x10] and err=0.
